// File: rtl/apb_slave_regfile_pkg.sv
// apb_slave_regfile_pkg: shared APB phase encoding and error-flag bit positions
package apb_slave_regfile_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} phase_e;
  localparam int ERR_SEQ    = 0;
  localparam int ERR_STABLE = 1;
  localparam int ERR_LEN    = 2;
endpackage

// File: rtl/apb_slave_regfile_phase_monitor.sv
// apb_slave_regfile_phase_monitor: APB phase tracking, setup capture and protocol checks
module apb_slave_regfile_phase_monitor
  import apb_slave_regfile_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          i_sel,
  input  logic          i_penable,
  input  logic          i_pwrite,
  input  logic [AW-1:0] i_paddr,
  input  logic [DW-1:0] i_pwdata,
  output phase_e        o_phase,
  output logic          o_write_q,
  output logic [IW-1:0] o_idx_q,
  output logic          o_access_ok,
  output logic [2:0]    o_err_set
);
  phase_e        r_state;
  phase_e        w_next;
  logic          w_acc;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [DW-1:0] r_wdata;
  // decode this cycle's phase and judge an access against the captured setup
  always_comb begin
    w_next = !i_sel ? IDLE : (i_penable ? ACCESS : SETUP);
    w_acc = w_next == ACCESS;
    o_err_set = '0;
    o_err_set[ERR_SEQ] = w_acc && r_state == IDLE;
    o_err_set[ERR_STABLE] = w_acc && r_state != IDLE &&
      (i_paddr != r_addr || i_pwrite != r_write || (r_write && i_pwdata != r_wdata));
    o_err_set[ERR_LEN] = w_acc && r_state == ACCESS;
    o_access_ok = w_acc && o_err_set == '0;
  end
  // previous-cycle phase plus transfer attributes latched at the setup edge
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == SETUP) begin
        r_addr  <= i_paddr;
        r_write <= i_pwrite;
        r_wdata <= i_pwdata;
      end
    end
  end
  assign o_phase   = w_next;
  assign o_write_q = r_write;
  assign o_idx_q   = r_addr[2 +: IW];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB2 register-file slave with protocol monitor and transfer counters
module apb_slave_regfile
  import apb_slave_regfile_pkg::*;
#(
  parameter int PSEL_IDX = 0,
  parameter int DEPTH    = 16,
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int CNT_W    = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [2:0]       PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [AW-1:0]    PADDR,
  input  logic [DW-1:0]    PWDATA,
  output logic [DW-1:0]    PRDATA,
  output logic [2:0]       err_flags,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
);
  localparam int IW = $clog2(DEPTH);
  logic [DW-1:0]    r_mem [DEPTH];
  logic [DW-1:0]    r_rdata;
  logic [2:0]       r_err;
  logic [CNT_W-1:0] r_wr;
  logic [CNT_W-1:0] r_rd;
  phase_e           w_phase;
  logic             w_write_q;
  logic [IW-1:0]    w_idx_q;
  logic             w_access_ok;
  logic [2:0]       w_err_set;
  logic [IW-1:0]    w_idx;
  logic             w_unused;
  assign w_idx    = PADDR[2 +: IW];
  assign w_unused = ^PSEL;
  apb_slave_regfile_phase_monitor #(.AW(AW), .DW(DW), .IW(IW)) u_mon (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .i_sel       (PSEL[PSEL_IDX]),
    .i_penable   (PENABLE),
    .i_pwrite    (PWRITE),
    .i_paddr     (PADDR),
    .i_pwdata    (PWDATA),
    .o_phase     (w_phase),
    .o_write_q   (w_write_q),
    .o_idx_q     (w_idx_q),
    .o_access_ok (w_access_ok),
    .o_err_set   (w_err_set)
  );
  // storage: read snapshot at setup, commit writes only on a clean access
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (w_phase == SETUP && !PWRITE) r_rdata <= r_mem[w_idx];
      if (w_access_ok && w_write_q) r_mem[w_idx_q] <= PWDATA;
    end
  end
  // completed-transfer counters and sticky violation flags (new violation beats clear)
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_err <= '0;
    end else begin
      if (w_access_ok && w_write_q) r_wr <= r_wr + CNT_W'(1);
      if (w_access_ok && !w_write_q) r_rd <= r_rd + CNT_W'(1);
      r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
    end
  end
  assign PRDATA    = (w_phase == ACCESS && !w_write_q) ? r_rdata : '0;
  assign err_flags = r_err;
  assign wr_count  = r_wr;
  assign rd_count  = r_rd;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: table, directed and random checks against a transaction-level model
module tb_apb_slave_regfile;
  localparam int CW = 8;
  logic          HCLK = 1'b0;
  logic          HRESET, PENABLE, PWRITE, err_clr;
  logic [2:0]    PSEL;
  logic [31:0]   PADDR, PWDATA, PRDATA;
  logic [2:0]    err_flags;
  logic [CW-1:0] wr_count, rd_count;
  int            errors = 0;
  int            checks = 0;
  logic [31:0]   mem_m [16];
  int            wr_m, rd_m;
  logic [2:0]    err_m;
  logic [31:0]   pr, pr_setup, v;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;
  vec_t tv [11];

  always #5 HCLK = ~HCLK;

  apb_slave_regfile #(.PSEL_IDX(0), .DEPTH(16), .DW(32), .AW(32), .CNT_W(CW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .err_flags(err_flags),
    .err_clr(err_clr), .wr_count(wr_count), .rd_count(rd_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] s, input logic en, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic rst = 1'b0, input logic clr = 1'b0);
    PSEL = s; PENABLE = en; PWRITE = w; PADDR = a; PWDATA = d; HRESET = rst; err_clr = clr;
    @(negedge HCLK);
    pr = PRDATA;
    @(posedge HCLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    wr_m = 0; rd_m = 0; err_m = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(3'b001, 1'b0, 1'b1, a, d);
    cyc(3'b001, 1'b1, 1'b1, a, d);
    mem_m[a[5:2]] = d;
    wr_m++;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    cyc(3'b001, 1'b0, 1'b0, a, 32'h0);
    pr_setup = pr;
    cyc(3'b001, 1'b1, 1'b0, a, 32'h0);
    r = pr;
    rd_m++;
  endtask

  task automatic chk_state(input string nm);
    chk({nm, ".wr_count"}, 32'(wr_count), 32'(wr_m & 255));
    chk({nm, ".rd_count"}, 32'(rd_count), 32'(rd_m & 255));
    chk({nm, ".err_flags"}, 32'(err_flags), 32'(err_m));
  endtask

  initial begin
    tv = '{'{1'b1, 32'h08, 32'hDEADBEEF}, '{1'b0, 32'h08, 32'hDEADBEEF},
           '{1'b1, 32'h04, 32'h11},       '{1'b0, 32'h04, 32'h11},
           '{1'b0, 32'hF000_0048, 32'hDEADBEEF}, '{1'b0, 32'h0B, 32'hDEADBEEF},
           '{1'b1, 32'h3C, 32'hFFFFFFFF}, '{1'b0, 32'h7C, 32'hFFFFFFFF},
           '{1'b0, 32'h20, 32'h0},        '{1'b1, 32'h22, 32'h5A5A},
           '{1'b0, 32'h20, 32'h5A5A}};
    model_reset();
    cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk_state("reset");
    chk("reset.prdata", PRDATA, 32'h0);

    for (int i = 0; i < 11; i++) begin
      if (tv[i].w) wr(tv[i].a, tv[i].d);
      else begin
        rd(tv[i].a, v);
        chk($sformatf("vec%0d.prdata", i), v, tv[i].d);
        chk($sformatf("vec%0d.setup_prdata", i), pr_setup, 32'h0);
      end
      chk_state($sformatf("vec%0d", i));
    end

    wr(32'h0C, 32'h33);
    cyc(3'b001, 1'b0, 1'b1, 32'h0C, 32'h55);
    cyc(3'b001, 1'b1, 1'b1, 32'h0C, 32'h55);
    cyc(3'b001, 1'b1, 1'b1, 32'h0C, 32'h55);
    wr_m++; mem_m[3] = 32'h55; err_m = 3'b100;
    chk_state("hold");
    rd(32'h0C, v);
    chk("hold.mem3", v, 32'h55);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    err_m = '0;
    chk_state("clr");

    wr(32'h10, 32'hA1);
    wr(32'h14, 32'hB2);
    cyc(3'b001, 1'b0, 1'b1, 32'h10, 32'h77);
    cyc(3'b001, 1'b1, 1'b1, 32'h14, 32'h77);
    err_m = 3'b010;
    chk_state("stable");
    rd(32'h10, v);
    chk("stable.mem4", v, 32'hA1);
    rd(32'h14, v);
    chk("stable.mem5", v, 32'hB2);
    chk_state("stable_after");

    cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(3'b001, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1);
    err_m = 3'b001;
    chk_state("clr_vs_seq");

    cyc(3'b001, 1'b0, 1'b1, 32'h00, 32'hAA);
    cyc(3'b001, 1'b1, 1'b1, 32'h00, 32'hAA, 1'b1);
    model_reset();
    chk_state("rst_mid");
    cyc(3'b001, 1'b1, 1'b1, 32'h00, 32'hAA);
    err_m = 3'b001;
    chk_state("seq_after_rst");
    rd(32'h00, v);
    chk("rst.mem0", v, 32'h0);
    cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    err_m = '0;

    wr(32'h08, 32'h12);
    cyc(3'b010, 1'b0, 1'b1, 32'h08, 32'h99);
    cyc(3'b010, 1'b1, 1'b1, 32'h08, 32'h99);
    chk_state("other_w");
    cyc(3'b010, 1'b0, 1'b0, 32'h08, 32'h0);
    cyc(3'b010, 1'b1, 1'b0, 32'h08, 32'h0);
    chk("other.prdata", pr, 32'h0);
    chk_state("other_r");
    rd(32'h08, v);
    chk("other.mem2", v, 32'h12);

    cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    model_reset();
    for (int i = 0; i < 255; i++) wr($urandom(), $urandom());
    chk("wrap.pre", 32'(wr_count), 32'd255);
    wr($urandom(), $urandom());
    chk("wrap.zero", 32'(wr_count), 32'd0);
    chk_state("wrap");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d, a2;
      logic [2:0]  s;
      logic        w;
      int          k;
      k = $urandom_range(0, 6);
      a = $urandom();
      d = $urandom();
      w = 1'($urandom_range(0, 1));
      case (k)
        0: wr(a, d);
        1: begin
          d = mem_m[a[5:2]];
          rd(a, v);
          chk($sformatf("rnd%0d.prdata", n), v, d);
        end
        2: begin
          s = $urandom_range(0, 1) ? 3'b010 : 3'b100;
          cyc(s, 1'b0, w, a, d);
          cyc(s, 1'b1, w, a, d);
          chk($sformatf("rnd%0d.other_prdata", n), pr, 32'h0);
        end
        3: begin
          cyc(3'b000, w, 1'b0, a, d);
          chk($sformatf("rnd%0d.idle_prdata", n), pr, 32'h0);
        end
        4: begin
          cyc(3'b001, 1'b0, 1'b1, a, d);
          cyc(3'b001, 1'b1, 1'b1, a, d);
          cyc(3'b001, 1'b1, 1'b1, a, d);
          mem_m[a[5:2]] = d; wr_m++; err_m[2] = 1'b1;
        end
        5: begin
          a2 = a ^ (32'h1 << $urandom_range(0, 31));
          cyc(3'b001, 1'b0, 1'b1, a, d);
          cyc(3'b001, 1'b1, 1'b1, a2, d);
          err_m[1] = 1'b1;
        end
        default: begin
          cyc(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
          err_m = '0;
        end
      endcase
      chk_state($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
